// File: rtl/rv_core_pkg.sv
// Shared core definitions: datapath width, reset PC, major opcodes and fetch state.
package rv_core_pkg;
    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush; head is visible combinationally on rdata.
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    // A pop frees the slot, so push-on-full is accepted when popping too
    assign w_pop  = pop && (r_cnt != '0);
    assign w_push = push && ((r_cnt != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= nxt(r_wr);
            if (w_pop)  r_rd <= nxt(r_rd);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    assign rdata = r_mem[r_rd];
    assign count = r_cnt;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited imem fetches, queues
// returned words in order and presents the head to the decoder.
module instr_fetch_unit
    import rv_core_pkg::*;
#(
    parameter int              XLEN     = rv_core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            advance,
    input  logic            pc_src,
    input  logic [XLEN-1:0] redirect_imm,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [6:0]      op_code,
    output logic [2:0]      funct3,
    output logic            funct7,
    output logic            fetch_err
);
    localparam int CW = $clog2(DEPTH+1);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_discard;
    logic            r_fetch_err;

    logic [CW-1:0]   w_occ;
    logic [CW-1:0]   w_outst;
    logic [CW:0]     w_credit;
    logic [XLEN-1:0] w_tag;
    logic [XLEN-1:0] w_q_pc;
    logic [XLEN-1:0] w_q_instr;
    logic [XLEN-1:0] w_target;
    logic            w_valid;
    logic            w_pop;
    logic            w_redirect;
    logic            w_misalign;
    logic            w_grant;
    logic            w_drop;
    logic            w_push;

    assign w_valid    = (r_state == RUN) && (w_occ != '0);
    assign w_pop      = w_valid && advance;
    assign w_redirect = w_pop && pc_src;
    assign w_target   = w_q_pc + redirect_imm;
    assign w_misalign = w_redirect && (w_target[1:0] != 2'b00);

    // Queued plus in-flight words never exceed the queue depth, so a response always has a slot
    assign w_credit  = {1'b0, w_occ} + {1'b0, w_outst};
    assign imem_req  = !rst && (r_state == RUN) && (w_credit < (CW+1)'(DEPTH)) && !w_redirect;
    assign imem_addr = r_fetch_pc;
    assign w_grant   = imem_req && imem_gnt;
    assign w_drop    = imem_rvalid && (r_discard != '0);
    assign w_push    = imem_rvalid && !w_drop && (r_state == RUN);

    // Tag FIFO occupancy doubles as the outstanding-fetch count
    ifu_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (w_grant),
        .wdata (r_fetch_pc),
        .pop   (imem_rvalid),
        .rdata (w_tag),
        .count (w_outst)
    );

    ifu_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_redirect || (r_state == HALT)),
        .push  (w_push),
        .wdata ({w_tag, imem_rdata}),
        .pop   (w_pop),
        .rdata ({w_q_pc, w_q_instr}),
        .count (w_occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_fetch_pc  <= RESET_PC;
            r_discard   <= '0;
            r_fetch_err <= 1'b0;
        end else if (w_redirect) begin
            // No grant can happen this cycle, so only the response lowers the in-flight count
            r_fetch_pc <= w_target;
            r_discard  <= w_outst - CW'(imem_rvalid);
            if (w_misalign) begin
                r_state     <= HALT;
                r_fetch_err <= 1'b1;
            end
        end else begin
            if (w_grant) r_fetch_pc <= r_fetch_pc + XLEN'(4);
            if (w_drop)  r_discard  <= r_discard - CW'(1);
        end
    end

    assign instr_valid = w_valid;
    assign instr       = w_valid ? w_q_instr : '0;
    assign pc          = w_valid ? w_q_pc : '0;
    assign pc_plus4    = w_valid ? (w_q_pc + XLEN'(4)) : '0;
    assign op_code     = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[30];
    assign fetch_err   = r_fetch_err;

    a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && (w_outst == '0)));
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the main/ALU decoder in the RISC-V core.
- Owns the program counter and issues word fetches to instruction memory over a req/gnt/rvalid handshake with variable latency.
- Buffers returned words in a small in-order queue and presents the head instruction, its PC and decoded fields (op_code, funct3, funct7) to the decoder.
- Applies taken-branch/jump redirects using the decoder's PC_Src and the sign-extender output.

Parameters:
RESET_PC, 32'h0000_1000, PC value loaded on reset
DEPTH, 2, instruction queue entries; also the cap on (queued + outstanding) fetches
XLEN, 32, address/data width

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch byte address, word aligned
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response data valid, one per granted request, in order
imem_rdata  in  XLEN  instruction word
advance  in  1  core consumes presented instruction this cycle
pc_src  in  1  redirect, i.e. Branch&zero | jump for the presented instruction
redirect_imm  in  XLEN  sign-extended offset for the redirect
instr_valid  out  1  instr/pc outputs valid
instr  out  XLEN  head instruction
pc  out  XLEN  PC of head instruction
pc_plus4  out  XLEN  pc + 4
op_code  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7  out  1  instr[30]
fetch_err  out  1  sticky: misaligned redirect target

Behaviour:
- Reset values (rst high at a clock edge):
  - fetch_pc = RESET_PC; queue empty; outstanding = 0; discard = 0.
  - State = RUN; imem_req = 0; instr_valid = 0; fetch_err = 0.
  - Data outputs are 0 while instr_valid = 0.
- Reset mid-transaction: responses already in flight after reset are not dropped by the discard counter. Memory must also be reset.
- States:
  - RUN: normal operation.
  - HALT: entered when a redirect target has addr[1:0] != 0. Sets fetch_err = 1; imem_req stays 0; queue is flushed; instr_valid = 0. HALT is left only by rst.
- Request rule: imem_req = (state == RUN) && (occupancy + outstanding < DEPTH) && !redirect_now.
  - imem_addr = fetch_pc.
  - While imem_req && !imem_gnt, addr is held stable and req is not withdrawn unless a redirect occurs.
- On grant (imem_req && imem_gnt): fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0); outstanding += 1.
- On imem_rvalid: outstanding -= 1.
  - If discard > 0: drop the word and decrement discard.
  - Else: push {pc_tag, rdata}. pc_tag comes from a tag FIFO written at grant time (same depth).
  - Overflow is impossible by the credit rule. An assertion fires if rvalid arrives with outstanding = 0.
- Output: the head entry is presented combinationally; instr_valid = occupancy > 0.
- Latency: with single-cycle gnt and rvalid the cycle after grant, the first instr_valid appears 2 cycles after rst falls. Steady throughput is 1 instruction/cycle with DEPTH >= 2.
- Consume: instr_valid && advance pops the head. Push and pop in the same cycle are allowed at any occupancy.
- Redirect: redirect_now = instr_valid && advance && pc_src; pc_src is ignored otherwise. In that cycle:
  - target = pc + redirect_imm (mod 2^32).
  - The queue is flushed, including any word pushed that cycle.
  - fetch_pc = target; imem_req = 0.
  - discard = outstanding after this cycle's grant/response accounting.
- The first request to the target issues the following cycle, and may overlap with discarded responses.

Decomposition:
- Shared package `rv_core_pkg`: XLEN, RESET_PC_DEFAULT, opcode constants (OP_LOAD 0000011, OP_STORE 0100011, OP_RTYPE 0110011, OP_ITYPE 0010011, OP_BRANCH 1100011, OP_JAL 1101111), fetch state enum {RUN, HALT}.
- One sub-module `ifu_fifo`: parameterised width/depth synchronous FIFO with flush, used twice (pc tags, instruction queue).

Test Plan:
- Reset release, imem gnt=1, rvalid 1 cycle after grant, advance=1 -> imem_addr sequence 0x1000, 0x1004, 0x1008; instr_valid first high 2 cycles after rst low; pc_plus4 = pc + 4.
- Stall: advance=0 for 5 cycles -> at most 2 requests granted, then imem_req=0; pc stays 0x1000 until advance returns; no word lost or duplicated.
- Redirect: presented pc=0x1008, pc_src=1, redirect_imm=0xFFFF_FFF8 with 1 outstanding fetch -> next imem_addr=0x1000; the stale 0x100C response is dropped; next presented pc=0x1000.
- Backpressure: imem_gnt low for 3 cycles -> imem_addr held at 0x1004; req stays high; after grant, in-order delivery is preserved.
- Misaligned: pc=0x1010, pc_src=1, redirect_imm=0x2 -> fetch_err=1, instr_valid=0, imem_req=0 until rst; rst restores pc=0x1000 fetch.
- Field decode: rdata=0x40B50533 (sub) -> op_code=0110011, funct3=000, funct7=1.
